alu_issue_ctrl: RTL and testbench

//  Initiator side of the ALU interface: accepts one instruction per transaction (valid/ready),

---
 rtl/alu_issue_ctrl_pkg.sv | 58 +++++
 rtl/alu_issue_ctrl.sv | 157 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_pkg
// Description : Shared constants, instruction opcodes, ALU mode codes and the
//               opcode decode helper for the ALU issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

  // Widest opcode the decode helper understands; narrower opcodes are
  // zero-extended into it by the caller.
  localparam int OPW_MAX = 16;

  // Instruction opcodes as presented by fetch/decode
  localparam logic [3:0] INSTR_ADD = 4'd0;
  localparam logic [3:0] INSTR_SUB = 4'd1;
  localparam logic [3:0] INSTR_AND = 4'd2;
  localparam logic [3:0] INSTR_OR  = 4'd3;
  localparam logic [3:0] INSTR_XOR = 4'd4;
  localparam logic [3:0] INSTR_CMP = 4'd5;

  // ALU mode codes driven on alu_mode
  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_AND = 8'h02;
  localparam logic [7:0] OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04;

  // Decoded view of one instruction opcode
  typedef struct packed {
    logic       legal;     // opcode is one the ALU can execute
    logic       carry_en;  // ALU carry is meaningful (arithmetic ops)
    logic       acc_wr;    // result is written back to the accumulator
    logic [7:0] mode;      // ALU mode code to issue
  } decode_t;

  // Map an instruction opcode to its ALU mode and side-effect flags.
  // CMP is a subtract whose result never reaches the accumulator.
  function automatic decode_t decode_op(input logic [OPW_MAX-1:0] op);
    decode_t d;
    d.legal    = 1'b1;
    d.carry_en = 1'b0;
    d.acc_wr   = 1'b1;
    d.mode     = OP_ADD;
    case (op)
      OPW_MAX'(INSTR_ADD): begin d.carry_en = 1'b1; d.mode = OP_ADD; end
      OPW_MAX'(INSTR_SUB): begin d.carry_en = 1'b1; d.mode = OP_SUB; end
      OPW_MAX'(INSTR_AND): d.mode = OP_AND;
      OPW_MAX'(INSTR_OR):  d.mode = OP_OR;
      OPW_MAX'(INSTR_XOR): d.mode = OP_XOR;
      OPW_MAX'(INSTR_CMP): begin d.carry_en = 1'b1; d.acc_wr = 1'b0; d.mode = OP_SUB; end
      default: begin d.legal = 1'b0; d.acc_wr = 1'b0; end
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Initiator side of the ALU interface. Accepts one instruction,
//               issues it to the ALU, waits out result and flag latency, and
//               returns result + flags on a valid/ready response channel.
//               Keeps an accumulator usable as operand A.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int N   = 8,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] instr_op,
  input  logic           instr_use_acc,
  input  logic [N-1:0]   instr_a,
  input  logic [N-1:0]   instr_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N-1:0]   res_data,
  output logic           res_zero,
  output logic           res_carry,
  output logic           res_err,
  output logic           alu_enable,
  output logic [N-1:0]   alu_mode,
  output logic [N-1:0]   alu_in_a,
  output logic [N-1:0]   alu_in_b,
  input  logic [N-1:0]   alu_out,
  input  logic           alu_flag_zero,
  input  logic           alu_flag_carry
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RES  = 3'd2,
    ST_WAIT_FLAG = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  decode_t      w_dec;
  logic         w_accept;
  logic         w_resp_done;
  logic         w_instr_ready;
  logic         w_res_valid;
  logic         w_alu_enable;

  logic [N-1:0] r_acc;
  logic [N-1:0] r_mode;
  logic [N-1:0] r_in_a;
  logic [N-1:0] r_in_b;
  logic         r_carry_en;
  logic         r_acc_wr;
  logic [N-1:0] r_res_data;
  logic         r_res_zero;
  logic         r_res_carry;
  logic         r_res_err;

  assign w_dec       = decode_op(OPW_MAX'(instr_op));
  assign w_accept    = w_instr_ready && instr_valid;
  assign w_resp_done = w_res_valid && res_ready;

  // Next-state and handshake/enable outputs, all derived from the current state
  always_comb begin
    w_state_nxt   = r_state;
    w_instr_ready = 1'b0;
    w_res_valid   = 1'b0;
    w_alu_enable  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_instr_ready = 1'b1;
        if (instr_valid) w_state_nxt = w_dec.legal ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        w_alu_enable = 1'b1;
        w_state_nxt  = ST_WAIT_RES;
      end
      ST_WAIT_RES:  w_state_nxt = ST_WAIT_FLAG;
      ST_WAIT_FLAG: w_state_nxt = ST_RESP;
      ST_RESP: begin
        w_res_valid = 1'b1;
        if (res_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset drops any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Latch the instruction on accept and collect ALU result/flags as they mature
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode      <= '0;
      r_in_a      <= '0;
      r_in_b      <= '0;
      r_carry_en  <= 1'b0;
      r_acc_wr    <= 1'b0;
      r_res_data  <= '0;
      r_res_zero  <= 1'b0;
      r_res_carry <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_carry_en <= w_dec.carry_en;
        r_acc_wr   <= w_dec.acc_wr;
        r_res_err  <= ~w_dec.legal;
        if (w_dec.legal) begin
          // ALU-facing registers only move for a real issue, so they hold otherwise
          r_mode <= N'(w_dec.mode);
          r_in_a <= instr_use_acc ? r_acc : instr_a;
          r_in_b <= instr_b;
        end else begin
          r_res_data  <= '0;
          r_res_zero  <= 1'b0;
          r_res_carry <= 1'b0;
        end
      end
      if (r_state == ST_WAIT_RES) begin
        r_res_data  <= alu_out;
        // Carry from the ALU is only defined for add/subtract
        r_res_carry <= r_carry_en & alu_flag_carry;
      end
      if (r_state == ST_WAIT_FLAG) r_res_zero <= alu_flag_zero;
    end
  end

  // Accumulator takes the result when the consumer accepts a writing op
  always_ff @(posedge clk) begin
    if (rst)                          r_acc <= '0;
    else if (w_resp_done && r_acc_wr) r_acc <= r_res_data;
  end

  assign instr_ready = w_instr_ready;
  assign res_valid   = w_res_valid;
  assign res_data    = r_res_data;
  assign res_zero    = r_res_zero;
  assign res_carry   = r_res_carry;
  assign res_err     = r_res_err;
  assign alu_enable  = w_alu_enable;
  assign alu_mode    = r_mode;
  assign alu_in_a    = r_in_a;
  assign alu_in_b    = r_in_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with a behavioural ALU
//               (result/carry one cycle after enable, zero one cycle later).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int N   = 8;
  localparam int OPW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           instr_valid;
  logic           instr_ready;
  logic [OPW-1:0] instr_op;
  logic           instr_use_acc;
  logic [N-1:0]   instr_a;
  logic [N-1:0]   instr_b;
  logic           res_valid;
  logic           res_ready;
  logic [N-1:0]   res_data;
  logic           res_zero;
  logic           res_carry;
  logic           res_err;
  logic           alu_enable;
  logic [N-1:0]   alu_mode;
  logic [N-1:0]   alu_in_a;
  logic [N-1:0]   alu_in_b;
  logic [N-1:0]   alu_out;
  logic           alu_flag_zero;
  logic           alu_flag_carry;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.N(N), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_use_acc(instr_use_acc), .instr_a(instr_a), .instr_b(instr_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_carry(res_carry), .res_err(res_err),
    .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_in_a(alu_in_a),
    .alu_in_b(alu_in_b), .alu_out(alu_out), .alu_flag_zero(alu_flag_zero),
    .alu_flag_carry(alu_flag_carry)
  );

  // Behavioural ALU: carry is garbage (1) for logic ops so forcing is visible
  logic [N:0] alu_r = '0;
  logic       alu_z = 1'b0;
  always @(posedge clk) begin
    if (alu_enable) begin
      case (alu_mode)
        OP_ADD:  alu_r <= {1'b0, alu_in_a} + {1'b0, alu_in_b};
        OP_SUB:  alu_r <= {1'b0, alu_in_a} - {1'b0, alu_in_b};
        OP_AND:  alu_r <= {1'b1, alu_in_a & alu_in_b};
        OP_OR:   alu_r <= {1'b1, alu_in_a | alu_in_b};
        OP_XOR:  alu_r <= {1'b1, alu_in_a ^ alu_in_b};
        default: alu_r <= {1'b1, 8'hAA};
      endcase
    end
    alu_z <= (alu_r[N-1:0] == '0);
  end
  assign alu_out        = alu_r[N-1:0];
  assign alu_flag_carry = alu_r[N];
  assign alu_flag_zero  = alu_z;

  // Count of issue cycles seen by the ALU
  int en_cnt = 0;
  always @(posedge clk) if (alu_enable) en_cnt <= en_cnt + 1;

  typedef struct {
    logic [3:0] op;
    logic       use_acc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] mode;
    logic [7:0] data;
    logic       zero;
    logic       carry;
    logic       err;
    int         hold;
  } vec_t;

  vec_t       vecs[12];
  vec_t       sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_acc  = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    instr_valid   = 1'b1;
    instr_op      = v.op;
    instr_use_acc = v.use_acc;
    instr_a       = v.a;
    instr_b       = v.b;
  endtask

  // Bounded wait for res_valid; lat already counts the accept edge
  task automatic wait_valid(inout int lat, output logic ok);
    while (!res_valid && lat < 20) begin
      step();
      lat++;
    end
    ok = res_valid;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: res_valid still %0b after %0d cycles", res_valid, lat);
    end
  endtask

  // Pop the oldest expected response and compare it with what the DUT shows
  task automatic compare_resp();
    vec_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: response with no expected entry (size %0d, need 1)", sb_q.size());
      return;
    end
    e = sb_q.pop_front();
    check("res_data",  res_data,  e.data);
    check("res_zero",  res_zero,  e.zero);
    check("res_carry", res_carry, e.carry);
    check("res_err",   res_err,   e.err);
    if (!e.err && e.op != INSTR_CMP) m_acc = e.data;
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    int   base;
    logic ok;
    drive(v);
    check("instr_ready_idle", instr_ready, 1);
    sb_q.push_back(v);
    base = en_cnt;
    step();
    instr_valid = 1'b0;
    lat = 1;
    if (!v.err) begin
      check("issue_enable", alu_enable, 1);
      check("issue_mode",   alu_mode,   v.mode);
      check("issue_a",      alu_in_a,   v.use_acc ? m_acc : v.a);
      check("issue_b",      alu_in_b,   v.b);
    end else begin
      check("illegal_no_enable", alu_enable, 0);
    end
    wait_valid(lat, ok);
    if (ok) begin
      check("latency", lat, v.err ? 1 : 4);
      compare_resp();
      for (int h = 0; h < v.hold; h++) begin
        if (h == 0) begin
          instr_valid = 1'b1;
          instr_op    = INSTR_ADD;
          instr_a     = 8'h01;
          instr_b     = 8'h01;
        end
        step();
        check("hold_valid", res_valid,   1);
        check("hold_data",  res_data,    v.data);
        check("hold_ready", instr_ready, 0);
      end
      instr_valid = 1'b0;
      res_ready   = 1'b1;
      step();
      res_ready = 1'b0;
      check("enable_count",  en_cnt - base, v.err ? 0 : 1);
      check("ready_after",   instr_ready,   1);
      check("valid_dropped", res_valid,     0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v1;
    vec_t v2;
    int   lat;
    logic ok;
    logic seen;

    //            op         acc   a      b      mode    data   z  c  e  hold
    vecs[0]  = '{INSTR_ADD, 1'b0, 8'hFF, 8'h01, OP_ADD, 8'h00, 1, 1, 0, 0};
    vecs[1]  = '{INSTR_SUB, 1'b0, 8'h05, 8'h07, OP_SUB, 8'hFE, 0, 1, 0, 0};
    vecs[2]  = '{INSTR_AND, 1'b1, 8'h00, 8'h0F, OP_AND, 8'h0E, 0, 0, 0, 0};
    vecs[3]  = '{INSTR_CMP, 1'b0, 8'h33, 8'h33, OP_SUB, 8'h00, 1, 0, 0, 0};
    vecs[4]  = '{INSTR_OR,  1'b1, 8'h00, 8'h30, OP_OR,  8'h3E, 0, 0, 0, 0};
    vecs[5]  = '{4'hF,      1'b0, 8'h12, 8'h34, 8'h00,  8'h00, 0, 0, 1, 0};
    vecs[6]  = '{4'h6,      1'b1, 8'h11, 8'h22, 8'h00,  8'h00, 0, 0, 1, 0};
    vecs[7]  = '{INSTR_ADD, 1'b1, 8'h00, 8'hC2, OP_ADD, 8'h00, 1, 1, 0, 0};
    vecs[8]  = '{INSTR_SUB, 1'b0, 8'h80, 8'h01, OP_SUB, 8'h7F, 0, 0, 0, 0};
    vecs[9]  = '{INSTR_CMP, 1'b0, 8'h01, 8'h02, OP_SUB, 8'hFF, 0, 1, 0, 0};
    vecs[10] = '{INSTR_AND, 1'b0, 8'h0F, 8'hF0, OP_AND, 8'h00, 1, 0, 0, 0};
    vecs[11] = '{INSTR_XOR, 1'b0, 8'hA5, 8'h5A, OP_XOR, 8'hFF, 0, 0, 0, 3};

    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_use_acc = 1'b0;
    instr_a = '0; instr_b = '0; res_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_instr_ready", instr_ready, 1);
    check("rst_res_valid",   res_valid,   0);
    check("rst_res_data",    res_data,    0);
    check("rst_res_flags",   {res_zero, res_carry, res_err}, 0);
    check("rst_alu_enable",  alu_enable,  0);
    check("rst_alu_bus",     {alu_mode, alu_in_a, alu_in_b}, 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset while the ALU result is pending: nothing comes back, acc cleared
    v1 = '{INSTR_ADD, 1'b0, 8'h10, 8'h20, OP_ADD, 8'h30, 0, 0, 0, 0};
    drive(v1);
    step();
    instr_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_acc = 8'h00;
    check("midrst_ready",  instr_ready, 1);
    check("midrst_enable", alu_enable,  0);
    check("midrst_valid",  res_valid,   0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    check("midrst_no_resp", seen, 0);
    v1 = '{INSTR_ADD, 1'b1, 8'hEE, 8'h07, OP_ADD, 8'h07, 0, 0, 0, 0};
    run_vec(v1);

    // Response handshake coincides with a new instruction: taken the cycle after
    v1 = '{INSTR_OR,  1'b0, 8'h0F, 8'hF0, OP_OR,  8'hFF, 0, 0, 0, 0};
    v2 = '{INSTR_SUB, 1'b0, 8'h09, 8'h03, OP_SUB, 8'h06, 0, 0, 0, 0};
    drive(v1);
    sb_q.push_back(v1);
    step();
    instr_valid = 1'b0;
    lat = 1;
    wait_valid(lat, ok);
    if (ok) begin
      compare_resp();
      res_ready = 1'b1;
      drive(v2);
      sb_q.push_back(v2);
      step();
      res_ready = 1'b0;
      check("ovl_ready",  instr_ready, 1);
      check("ovl_enable", alu_enable,  0);
      check("ovl_valid",  res_valid,   0);
      step();
      instr_valid = 1'b0;
      check("ovl_issue", alu_enable, 1);
      check("ovl_mode",  alu_mode,   OP_SUB);
      check("ovl_a",     alu_in_a,   8'h09);
      lat = 1;
      wait_valid(lat, ok);
      if (ok) begin
        check("ovl_latency", lat, 4);
        compare_resp();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
